// File: rtl/alu_pkg.sv
// Shared opcodes, action-word field positions and container widths for the
// 4-byte ALU lanes of the RMT action stage.
package alu_pkg;

  localparam int CONT_W16 = 16;
  localparam int CONT_W32 = 32;
  localparam int CONT_W48 = 48;

  localparam int OPC_HI = 24;
  localparam int OPC_LO = 21;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1011;
  localparam logic [3:0] OP_LOADD = 4'b1100;

  typedef enum logic {
    CLR_INIT = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/alu_4b_stateful_if.sv
// Crossbar-side bundle of one 4B ALU lane: operands and action in, result
// container and status out.
interface alu_4b_stateful_if #(
  parameter int ACT_LEN = 25
);
  logic               alu_in_valid;
  logic [ACT_LEN-1:0] action_in;
  logic [31:0]        operand_1;
  logic [31:0]        operand_2;
  logic [31:0]        operand_3;
  logic               alu_ready;
  logic [31:0]        container_out;
  logic               container_out_valid;
  logic               drop_err;

  modport master (
    output alu_in_valid, action_in, operand_1, operand_2, operand_3,
    input  alu_ready, container_out, container_out_valid, drop_err
  );

  modport slave (
    input  alu_in_valid, action_in, operand_1, operand_2, operand_3,
    output alu_ready, container_out, container_out_valid, drop_err
  );
endinterface

// File: rtl/alu_state_ram.sv
// Per-lane stateful memory: simple dual-port, synchronous read-first, no reset
// (contents are zeroed by the owning lane's clear sweep).
module alu_state_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Read and write on the same edge: the read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/alu_4b_stateful.sv
// One 4-byte ALU lane with a small stateful memory and a two-cycle result latency.
// Optional feature macro: STATEFUL_LOADD_EN enables the load-increment-store opcode.
module alu_4b_stateful
  import alu_pkg::*;
#(
  parameter int STAGE   = 0,
  parameter int ADDR_W  = 4,
  parameter int ACT_LEN = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_4b_stateful_if.slave bus
);
  localparam int DEPTH        = 1 << ADDR_W;
  localparam int stage_unused = STAGE;

  clr_state_e          state;
  logic [ADDR_W-1:0]   clr_addr;
  logic                alu_ready_r;
  logic                drop_err_r;

  logic [ACT_LEN-1:0]  action_w;
  logic [3:0]          opc_p0;
  logic [ADDR_W-1:0]   rd_addr_p0;
  logic                acc_p0;
  logic                unused_bits;

  logic                vld_p1;
  logic [3:0]          opc_p1;
  logic [CONT_W32-1:0] op1_p1;
  logic [CONT_W32-1:0] op2_p1;
  logic [CONT_W32-1:0] op3_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic                fwd_hit_p1;
  logic [CONT_W32-1:0] fwd_data_p1;
  logic [CONT_W32-1:0] ram_rd_p1;
  logic [CONT_W32-1:0] mem_val_p1;
  logic                op_wr_p1;
  logic [CONT_W32-1:0] op_wr_data_p1;
  logic [CONT_W32-1:0] res_p1;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [CONT_W32-1:0] wr_data;

  logic                vld_p2;
  logic [CONT_W32-1:0] container_p2;

  assign action_w    = bus.action_in;
  assign opc_p0      = action_w[OPC_HI:OPC_LO];
  assign rd_addr_p0  = bus.operand_2[ADDR_W-1:0];
  assign acc_p0      = bus.alu_in_valid && alu_ready_r;
  assign unused_bits = ^action_w;

  // Clear sweep after reset; ops arriving before it completes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLR_INIT;
      clr_addr    <= '0;
      alu_ready_r <= 1'b0;
      drop_err_r  <= 1'b0;
    end else begin
      if (bus.alu_in_valid && !alu_ready_r) drop_err_r <= 1'b1;
      case (state)
        CLR_INIT: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state       <= CLR_RUN;
            alu_ready_r <= 1'b1;
          end
        end
        default: alu_ready_r <= 1'b1;
      endcase
    end
  end

  // ---- stage p0 -> p1: capture op, issue RAM read ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= acc_p0;
  end

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      opc_p1  <= opc_p0;
      op1_p1  <= bus.operand_1;
      op2_p1  <= bus.operand_2;
      op3_p1  <= bus.operand_3;
      addr_p1 <= rd_addr_p0;
    end
    // The RAM returns pre-write data when stage 2 writes the address being read.
    fwd_hit_p1  <= op_wr_p1 && (addr_p1 == rd_addr_p0);
    fwd_data_p1 <= op_wr_data_p1;
  end

  alu_state_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (CONT_W32)
  ) u_state_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_p0),
    .rd_data (ram_rd_p1)
  );

  // ---- stage p1 -> p2: compute, write back, register result ----
  assign mem_val_p1 = fwd_hit_p1 ? fwd_data_p1 : ram_rd_p1;

`ifdef STATEFUL_LOADD_EN
  logic [CONT_W32-1:0] inc_val_p1;
  assign inc_val_p1    = mem_val_p1 + 32'd1;
  assign op_wr_p1      = vld_p1 && ((opc_p1 == OP_STORE) || (opc_p1 == OP_LOADD));
  assign op_wr_data_p1 = (opc_p1 == OP_STORE) ? op1_p1 : inc_val_p1;
`else
  assign op_wr_p1      = vld_p1 && (opc_p1 == OP_STORE);
  assign op_wr_data_p1 = op1_p1;
`endif

  always_comb begin
    wr_en   = op_wr_p1;
    wr_addr = addr_p1;
    wr_data = op_wr_data_p1;
    if (state == CLR_INIT) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end
  end

  always_comb begin
    res_p1 = op3_p1;
    case (opc_p1)
      OP_ADD, OP_ADDI: res_p1 = op1_p1 + op2_p1;
      OP_SUB, OP_SUBI: res_p1 = op1_p1 - op2_p1;
      OP_LOAD:         res_p1 = mem_val_p1;
`ifdef STATEFUL_LOADD_EN
      OP_LOADD:        res_p1 = inc_val_p1;
`endif
      default:         res_p1 = op3_p1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2       <= 1'b0;
      container_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) container_p2 <= res_p1;
    end
  end

  assign bus.container_out       = container_p2;
  assign bus.container_out_valid = vld_p2;
  assign bus.alu_ready           = alu_ready_r;
  assign bus.drop_err            = drop_err_r;

endmodule

// File: tb/tb_alu_4b_stateful.sv
// Bench for alu_4b_stateful: sequential reference model compared every cycle,
// plus directed sequences with literal expectations.
module tb_alu_4b_stateful;
  import alu_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_4b_stateful_if #(.ACT_LEN(25)) bus ();

  alu_4b_stateful #(.STAGE(0), .ADDR_W(4), .ACT_LEN(25)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: ops execute one after another in arrival order.
  logic [31:0] m_mem [DEPTH];
  int          m_cnt = 0;
  logic        m_v1 = 1'b0, m_vout = 1'b0, m_drop = 1'b0;
  logic [31:0] m_d1 = '0, m_last = '0;
  logic [31:0] out_log [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_v1   <= 1'b0;
      m_vout <= 1'b0;
      m_last <= '0;
      m_drop <= 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else begin
      m_vout <= m_v1;
      if (m_v1) m_last <= m_d1;
      m_v1 <= 1'b0;
      if (bus.alu_in_valid) begin
        if (m_cnt >= DEPTH) begin
          int a;
          a = int'(bus.operand_2 % DEPTH);
          m_v1 <= 1'b1;
          case (bus.action_in[24:21])
            OP_ADD, OP_ADDI: m_d1 <= bus.operand_1 + bus.operand_2;
            OP_SUB, OP_SUBI: m_d1 <= bus.operand_1 - bus.operand_2;
            OP_LOAD:         m_d1 <= m_mem[a];
            OP_STORE: begin
              m_mem[a] <= bus.operand_1;
              m_d1     <= bus.operand_3;
            end
`ifdef STATEFUL_LOADD_EN
            OP_LOADD: begin
              m_mem[a] <= m_mem[a] + 32'd1;
              m_d1     <= m_mem[a] + 32'd1;
            end
`endif
            default: m_d1 <= bus.operand_3;
          endcase
        end else begin
          m_drop <= 1'b1;
        end
      end
      if (m_cnt < DEPTH) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus.container_out_valid !== m_vout) begin
        failures++;
        $display("FAIL mon_valid t=%0t: got %b expected %b", $time, bus.container_out_valid, m_vout);
      end
      checks++;
      if (bus.container_out !== m_last) begin
        failures++;
        $display("FAIL mon_data t=%0t: got %h expected %h", $time, bus.container_out, m_last);
      end
      checks++;
      if (bus.alu_ready !== (m_cnt >= DEPTH)) begin
        failures++;
        $display("FAIL mon_ready t=%0t: got %b expected %b", $time, bus.alu_ready, (m_cnt >= DEPTH));
      end
      checks++;
      if (bus.drop_err !== m_drop) begin
        failures++;
        $display("FAIL mon_drop t=%0t: got %b expected %b", $time, bus.drop_err, m_drop);
      end
      if (bus.container_out_valid === 1'b1) out_log.push_back(bus.container_out);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < out_log.size()) ? out_log[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic set_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
    bus.alu_in_valid = 1'b1;
    bus.action_in    = {opc, 5'd0, b[15:0]};
    bus.operand_1    = a;
    bus.operand_2    = b;
    bus.operand_3    = c;
  endtask

  task automatic drive(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    set_op(opc, a, b, c);
    @(negedge clk);
  endtask

  task automatic settle();
    bus.alu_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm, input int drop_cycle);
    int rise;
    rise = 0;
    for (int i = 1; i <= 40 && rise == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.alu_ready === 1'b1) rise = i;
      @(negedge clk);
      if (i == drop_cycle - 1) set_op(OP_ADD, 32'd1, 32'd1, 32'd0);
      else bus.alu_in_valid = 1'b0;
    end
    chk(nm, 32'(rise), 32'd16);
  endtask

  logic [31:0] e_mem [4];
  logic [31:0] e_mix [6] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFE,
                             32'h0001_0063, 32'hFFFF_FFF0, 32'hCAFE_F00D};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alu_in_valid = 1'b0;
    bus.action_in    = '0;
    bus.operand_1    = '0;
    bus.operand_2    = '0;
    bus.operand_3    = '0;
    #1 rst_n = 1'b0;
    #1 mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out", bus.container_out, 32'd0);
    chk("rst_ready", 32'(bus.alu_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ready after 16 clear cycles; an op in cycle 5 is dropped.
    wait_ready("ready_rise", 5);
    chk("drop_err_set", 32'(bus.drop_err), 32'd1);
    settle();
    chk("drop_no_out", 32'(out_log.size()), 32'd0);

    // add wraps, result valid two edges after the input.
    set_op(OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0);
    @(posedge clk);
    #1;
    bus.alu_in_valid = 1'b0;
    chk("add_lat_e0", 32'(bus.container_out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("add_lat_e1", 32'(bus.container_out_valid), 32'd1);
    chk("add_wrap", bus.container_out, 32'h0000_0001);
    settle();
    out_log.delete();

    // store then load back-to-back.
    drive(OP_STORE, 32'hDEAD_BEEF, 32'd3, 32'hAAAA_0001);
    drive(OP_LOAD, 32'd0, 32'd3, 32'h0000_0055);
    settle();
    chk("st_out", log_at(0), 32'hAAAA_0001);
    chk("ld_after_st", log_at(1), 32'hDEAD_BEEF);
    out_log.delete();

    // loadd x3 on cleared addr 7, then load.
`ifdef STATEFUL_LOADD_EN
    e_mem = '{32'd1, 32'd2, 32'd3, 32'd3};
`else
    e_mem = '{32'h0C0C_0C0C, 32'h0C0C_0C0C, 32'h0C0C_0C0C, 32'd0};
`endif
    repeat (3) drive(OP_LOADD, 32'd0, 32'd7, 32'h0C0C_0C0C);
    drive(OP_LOAD, 32'd0, 32'd7, 32'h0000_0066);
    settle();
    for (int i = 0; i < 4; i++) chk($sformatf("loadd_%0d", i), log_at(i), e_mem[i]);
    out_log.delete();

    // passthrough, aliased load, sub/addi/subi, unknown opcode.
    drive(4'b0000, 32'd1, 32'd2, 32'h1234_5678);
    drive(OP_LOAD, 32'd0, 32'h0000_0013, 32'h0000_0077);
    drive(OP_SUB, 32'd5, 32'd7, 32'd0);
    drive(OP_ADDI, 32'd100, 32'h0000_FFFF, 32'd0);
    drive(OP_SUBI, 32'h10, 32'h20, 32'd0);
    drive(4'b1111, 32'd9, 32'd9, 32'hCAFE_F00D);
    settle();
    for (int i = 0; i < 6; i++) chk($sformatf("mix_%0d", i), log_at(i), e_mix[i]);
    out_log.delete();

    // Store, idle gap, load through an aliased address.
    drive(OP_STORE, 32'h0BAD_F00D, 32'h0000_001F, 32'h0000_0001);
    bus.alu_in_valid = 1'b0;
    @(negedge clk);
    drive(OP_LOAD, 32'd0, 32'h0000_000F, 32'h0000_0002);
    settle();
    chk("gap_st", log_at(0), 32'h0000_0001);
    chk("gap_ld", log_at(1), 32'h0BAD_F00D);
    out_log.delete();

    // Reset with ops in flight discards them and restarts the clear sweep.
    drive(OP_ADD, 32'd1, 32'd1, 32'd0);
    set_op(OP_ADD, 32'd2, 32'd2, 32'd0);
    #2 rst_n = 1'b0;
    bus.alu_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_inflight", 32'(out_log.size()), 32'd0);
    chk("rst_drop_clr", 32'(bus.drop_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("ready_rise2", 0);
    drive(OP_LOAD, 32'd0, 32'd3, 32'd0);
    settle();
    chk("mem_cleared", log_at(0), 32'd0);
    chk("drop_after_rst", 32'(bus.drop_err), 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
